// File: rtl/tinytpu_result_serializer.sv
// Result-matrix serializer: captures one N x N result frame and shifts it out bit-serially,
// paced by the host through tx_en.
//
// state | meaning
// IDLE  | waiting for res_valid, res_ready high
// SHIFT | frame bits presented on data_out_z, one consumed per tx_en edge
// DONE  | single-cycle tx_done pulse before returning to IDLE
module tinytpu_result_serializer #(
    parameter int N     = 2,
    parameter int RES_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 res_valid,
    input  logic [N*N*RES_W-1:0] res_data,
    output logic                 res_ready,
    input  logic                 tx_en,
    output logic                 data_out_z,
    output logic                 tx_ready,
    output logic                 tx_done
);

    localparam int TOT_BITS = N * N * RES_W;
    localparam int CNT_W    = (TOT_BITS > 1) ? $clog2(TOT_BITS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOT_BITS - 1);

    logic [1:0]          state;
    logic [TOT_BITS-1:0] shreg;
    logic [TOT_BITS-1:0] load_val;
    logic [CNT_W-1:0]    bit_cnt;

    // Word 0 lands in the top slot so that always emitting the MSB gives word order 0..N*N-1.
    always_comb begin
        load_val = '0;
        for (int i = 0; i < N * N; i++) begin
            load_val[TOT_BITS-1-i*RES_W -: RES_W] = res_data[i*RES_W +: RES_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (init) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (res_valid) begin
                        shreg   <= load_val;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tx_en) begin
                        shreg <= {shreg[TOT_BITS-2:0], 1'b0};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= ST_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign res_ready  = (state == ST_IDLE);
    assign tx_ready   = (state == ST_SHIFT);
    assign tx_done    = (state == ST_DONE);
    assign data_out_z = tx_ready & shreg[TOT_BITS-1];

endmodule

// File: tb/tb_tinytpu_result_serializer.sv
// Directed bench for tinytpu_result_serializer: frame table plus hand-written abort,
// reset and back-to-back sequences. Inputs change and outputs are sampled on negedge.
module tb_tinytpu_result_serializer;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_ready;
    logic        tx_en;
    logic        data_out_z;
    logic        tx_ready;
    logic        tx_done;

    int n_total;
    int n_pass;

    tinytpu_result_serializer #(.N(2), .RES_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .tx_en      (tx_en),
        .data_out_z (data_out_z),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] data;    // flat res_data = {w3, w2, w1, w0}
        logic [63:0] stream;  // expected serial stream, first bit at [63]
        int          mode;    // 0: tx_en always 1, 1: tx_en pattern 1,0,0
        int          inject;  // bit index at which a busy res_valid is driven, -1 none
    } frame_vec_t;

    frame_vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic run_frame(input frame_vec_t v);
        int  k;
        int  cyc;
        int  rdy_cnt;
        bit  done;
        bit  en;
        bit  prev_en;
        logic prev_bit;
        logic [63:0] ones;
        ones = '1;
        @(negedge clk);
        chk({v.name, "_idle_ready"}, res_ready, 1);
        res_data  = v.data;
        res_valid = 1'b1;
        tx_en     = 1'b0;
        @(negedge clk);
        res_valid = 1'b0;
        k = 0; cyc = 0; rdy_cnt = 0; done = 0; prev_en = 0; prev_bit = 1'b0;
        while (!done && cyc < 500) begin
            if (tx_done) begin
                chk({v.name, "_bits_before_done"}, 64'(k), 64);
                done = 1;
                tx_en = 1'b0;
                res_valid = 1'b0;
            end else begin
                chk({v.name, "_tx_ready"}, tx_ready, 1);
                chk({v.name, "_res_ready_busy"}, res_ready, 0);
                rdy_cnt++;
                if (cyc > 0 && !prev_en) chk({v.name, "_hold_stable"}, data_out_z, prev_bit);
                en = (v.mode == 0) ? 1'b1 : (cyc % 3 == 0);
                tx_en = en;
                res_valid = (k == v.inject) && en;
                if (k == v.inject && en) res_data = ones;
                if (en) begin
                    if (k < 64) chk({v.name, "_bit"}, data_out_z, v.stream[63-k]);
                    k++;
                end
                prev_en  = en;
                prev_bit = data_out_z;
            end
            cyc++;
            if (!done) @(negedge clk);
        end
        if (!done) chk({v.name, "_timeout_waiting_done"}, 0, 1);
        if (v.mode == 0) chk({v.name, "_ready_cycles"}, 64'(rdy_cnt), 64);
        @(negedge clk);
        chk({v.name, "_post_res_ready"}, res_ready, 1);
        chk({v.name, "_post_tx_done"}, tx_done, 0);
        // a busy-time res_valid must not have started a second frame
        @(negedge clk);
        chk({v.name, "_no_second_frame"}, tx_ready, 0);
    endtask

    initial begin
        int first_rise;
        int second_rise;
        int rises;
        logic prev_rdy;
        frame_vec_t fresh;

        n_total = 0; n_pass = 0;
        rst_n = 1'b0; init = 1'b0; res_valid = 1'b0; res_data = '0; tx_en = 1'b0;

        vecs[0] = '{"basic",   64'h00FF_A5A5_8000_0001, 64'h0001_8000_A5A5_00FF, 0, -1};
        vecs[1] = '{"paced",   64'h00FF_A5A5_8000_0001, 64'h0001_8000_A5A5_00FF, 1, -1};
        vecs[2] = '{"pattern", 64'h8001_0000_FFFF_1234, 64'h1234_FFFF_0000_8001, 0, -1};
        vecs[3] = '{"busy",    64'h00FF_A5A5_8000_0001, 64'h0001_8000_A5A5_00FF, 0, 10};

        #12;
        chk("rst_res_ready", res_ready, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_data", data_out_z, 0);
        chk("rst_tx_done", tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Abort with init and a simultaneous res_valid at bit 20.
        @(negedge clk);
        res_data = 64'h00FF_A5A5_8000_0001;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        tx_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_pre_tx_ready", tx_ready, 1);
        init = 1'b1;
        res_valid = 1'b1;
        res_data = '1;
        @(negedge clk);
        init = 1'b0; res_valid = 1'b0; tx_en = 1'b0;
        chk("abort_res_ready", res_ready, 1);
        chk("abort_tx_ready", tx_ready, 0);
        chk("abort_tx_done", tx_done, 0);
        chk("abort_data", data_out_z, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", tx_done, 0);
            chk("abort_no_capture", tx_ready, 0);
        end
        fresh = '{"after_abort", 64'h8001_0000_FFFF_1234, 64'h1234_FFFF_0000_8001, 0, -1};
        run_frame(fresh);

        // Asynchronous reset between edges, mid-frame.
        @(negedge clk);
        res_data = 64'hFFFF_FFFF_FFFF_FFFF;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        tx_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_data", data_out_z, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_res_ready", res_ready, 1);
        chk("async_rst_tx_ready", tx_ready, 0);
        chk("async_rst_data", data_out_z, 0);
        chk("async_rst_tx_done", tx_done, 0);
        tx_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", tx_ready, 0);

        // Back-to-back: res_valid held high, expect a 66-cycle frame period.
        res_data = 64'h00FF_A5A5_8000_0001;
        res_valid = 1'b1;
        tx_en = 1'b1;
        rises = 0; first_rise = 0; second_rise = 0; prev_rdy = 1'b0;
        for (int c = 0; c < 300 && rises < 2; c++) begin
            @(negedge clk);
            if (tx_ready && !prev_rdy) begin
                if (rises == 0) first_rise = c;
                else second_rise = c;
                rises++;
            end
            prev_rdy = tx_ready;
        end
        if (rises < 2) chk("b2b_timeout", 64'(rises), 2);
        else chk("b2b_period", 64'(second_rise - first_rise), 66);
        res_valid = 1'b0;
        tx_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
